// File: rtl/custom_types_pkg.sv
// Shared types for the instruction cache: frame, address split, FSM state.
// No ports; imported by icache, icache_stats and icache_if.
package custom_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - 2 - ICACHE_IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } icache_state_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icache_addr_t;

endpackage

// File: rtl/icache_if.sv
// Fetch/memory bundle around the icache.
// Modports: icache (this block), dp (fetch side), mem (memory controller).
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport icache (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport dp (
        output imemREN, imemaddr,
        input  ihit, imemload
    );

    modport mem (
        input  iREN, iaddr,
        output iwait, iload
    );

endinterface

// File: rtl/icache_stats.sv
// Saturating hit/miss counters for the icache (used under ICACHE_STATS_EN).
// Ports: CLK, nRST, hit_inc_i, miss_inc_i, hit_count_o, miss_count_o.
module icache_stats (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        hit_inc_i,
    input  logic        miss_inc_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    logic [31:0] hit_q, hit_d;
    logic [31:0] miss_q, miss_d;

    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (hit_inc_i && hit_q != 32'hFFFF_FFFF) begin
            hit_d = hit_q + 32'd1;
        end
        if (miss_inc_i && miss_q != 32'hFFFF_FFFF) begin
            miss_d = miss_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with single-word refill.
// Ports: CLK/nRST, fetch (imemREN, imemaddr, ihit, imemload), memory
// (iREN, iaddr, iwait, iload); hit_count/miss_count under ICACHE_STATS_EN.
module icache
    import custom_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    icache_frame_t frames_q [ICACHE_SETS];
    icache_state_t state_q, state_d;
    logic [31:0]   miss_addr_q, miss_addr_d;

    icache_addr_t  req;
    icache_addr_t  miss;
    icache_frame_t look;
    logic          hit;
    logic          fill_we;
    logic          unused_bits;

    assign req  = imemaddr;
    assign miss = miss_addr_q;
    assign look = frames_q[req.idx];
    assign hit  = imemREN & look.valid & (look.tag == req.tag);
    assign unused_bits = ^{req.bytoff, miss.bytoff};

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        ihit        = 1'b0;
        imemload    = '0;
        iREN        = 1'b0;
        iaddr       = '0;
        fill_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ihit = hit;
                if (hit) begin
                    imemload = look.data;
                end
                if (imemREN && !hit) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = FILL;
                end
            end
            FILL: begin
                // Fetch-side inputs are ignored here; the fill finishes
                // to the latched address and the next lookup happens in IDLE.
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ICACHE_SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else if (fill_we) begin
            frames_q[miss.idx] <= '{valid: 1'b1, tag: miss.tag, data: iload};
        end
    end

`ifdef ICACHE_STATS_EN
    icache_stats u_stats (
        .CLK          (CLK),
        .nRST         (nRST),
        .hit_inc_i    (ihit),
        .miss_inc_i   (state_q == IDLE && imemREN && !hit),
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count)
    );
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Covers cold miss, warm hit, idle, eviction, redirect and reset mid-fill.
module tb_icache;

    logic CLK;
    logic nRST;
    int   errs;
    int   total;

    icache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (bus.imemREN),
        .imemaddr   (bus.imemaddr),
        .ihit       (bus.ihit),
        .imemload   (bus.imemload),
        .iREN       (bus.iREN),
        .iaddr      (bus.iaddr),
        .iwait      (bus.iwait),
        .iload      (bus.iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    // Miss on addr, hold iwait for waits FILL cycles, then return data.
    // Leaves the bench #1 after the edge that returns to IDLE.
    task automatic fill(input string tag,
                        input logic [31:0] addr,
                        input int waits,
                        input logic [31:0] data);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        bus.iwait    = 1'b1;
        @(negedge CLK);
        check({tag, "_miss_ihit"}, {31'd0, bus.ihit}, 32'd0);
        next();
        for (int i = 0; i < waits; i++) begin
            @(negedge CLK);
            check({tag, "_wait_iREN"}, {31'd0, bus.iREN}, 32'd1);
            check({tag, "_wait_iaddr"}, bus.iaddr, addr);
            next();
        end
        bus.iwait = 1'b0;
        bus.iload = data;
        @(negedge CLK);
        check({tag, "_last_iREN"}, {31'd0, bus.iREN}, 32'd1);
        check({tag, "_last_iaddr"}, bus.iaddr, addr);
        check({tag, "_last_ihit"}, {31'd0, bus.ihit}, 32'd0);
        next();
        bus.iwait = 1'b1;
        bus.iload = 32'h0;
    endtask

    initial begin
        errs  = 0;
        total = 0;
        nRST  = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;

        @(negedge CLK);
        check("rst_ihit", {31'd0, bus.ihit}, 32'd0);
        check("rst_iREN", {31'd0, bus.iREN}, 32'd0);
        check("rst_iaddr", bus.iaddr, 32'h0);
        check("rst_load", bus.imemload, 32'h0);
        next();
        nRST = 1'b1;

        // Cold miss: 3 wait cycles plus the final fill cycle.
        fill("cold", 32'h0000_0040, 3, 32'h2001_0005);
        @(negedge CLK);
        check("cold_ihit", {31'd0, bus.ihit}, 32'd1);
        check("cold_load", bus.imemload, 32'h2001_0005);
        check("cold_iREN", {31'd0, bus.iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
        check("cold_miss_cnt", miss_count, 32'd1);
        check("cold_hit_cnt", hit_count, 32'd0);
`endif
        next();

        // Warm hit, same address re-requested.
        @(negedge CLK);
        check("warm_ihit", {31'd0, bus.ihit}, 32'd1);
        check("warm_iREN", {31'd0, bus.iREN}, 32'd0);
        check("warm_load", bus.imemload, 32'h2001_0005);
`ifdef ICACHE_STATS_EN
        check("warm_hit_cnt", hit_count, 32'd1);
`endif
        next();

        // Idle: no request, cached address present.
        bus.imemREN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("idle_ihit", {31'd0, bus.ihit}, 32'd0);
            check("idle_iREN", {31'd0, bus.iREN}, 32'd0);
`ifdef ICACHE_STATS_EN
            check("idle_hit_cnt", hit_count, 32'd2);
            check("idle_miss_cnt", miss_count, 32'd1);
`endif
            next();
        end
        bus.imemREN = 1'b1;
        @(negedge CLK);
        check("idle_after_hit", {31'd0, bus.ihit}, 32'd1);
        next();

        // Conflict: 0x440 maps to index 0 like 0x40.
        fill("evict", 32'h0000_0440, 1, 32'hDEAD_BEEF);
        @(negedge CLK);
        check("evict_ihit", {31'd0, bus.ihit}, 32'd1);
        check("evict_load", bus.imemload, 32'hDEAD_BEEF);
        next();
        fill("refill40", 32'h0000_0040, 0, 32'h2001_0005);
        @(negedge CLK);
        check("refill40_load", bus.imemload, 32'h2001_0005);
        next();

        // Redirect while filling 0x80.
        bus.imemaddr = 32'h0000_0080;
        @(negedge CLK);
        check("redir_miss", {31'd0, bus.ihit}, 32'd0);
        next();
        bus.imemaddr = 32'h0000_0100;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("redir_iaddr", bus.iaddr, 32'h0000_0080);
            check("redir_ihit", {31'd0, bus.ihit}, 32'd0);
            next();
        end
        bus.iwait = 1'b0;
        bus.iload = 32'h1111_0080;
        @(negedge CLK);
        check("redir_last", bus.iaddr, 32'h0000_0080);
        next();
        bus.iwait    = 1'b1;
        bus.imemaddr = 32'h0000_0080;
        @(negedge CLK);
        check("redir_frame", bus.imemload, 32'h1111_0080);
        next();
        fill("new100", 32'h0000_0100, 0, 32'h2222_0100);
        @(negedge CLK);
        check("new100_load", bus.imemload, 32'h2222_0100);
        next();

        // Reset mid-fill after 0x40 is cached.
        fill("pre_rst", 32'h0000_0040, 0, 32'h2001_0005);
        @(negedge CLK);
        check("pre_rst_hit", {31'd0, bus.ihit}, 32'd1);
        next();
        bus.imemaddr = 32'h0000_0440;
        next();
        @(negedge CLK);
        check("rstfill_iREN", {31'd0, bus.iREN}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        check("rstfill_drop", {31'd0, bus.iREN}, 32'd0);
        next();
        nRST = 1'b1;
        bus.imemaddr = 32'h0000_0040;
        @(negedge CLK);
        check("post_rst_miss", {31'd0, bus.ihit}, 32'd0);
`ifdef ICACHE_STATS_EN
        check("post_rst_hcnt", hit_count, 32'd0);
`endif
        next();
        @(negedge CLK);
        check("post_rst_fill", bus.iaddr, 32'h0000_0040);

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Responder side of the fetch instruction-memory request.
- The fetch stage drives imemREN/imemaddr and holds them until ihit. This block answers with ihit/imemload from a direct-mapped, one-word-per-frame instruction cache.
- On a miss it issues a single-word read to the memory controller (iREN/iaddr, iwait/iload) and refills the frame.
- Sits between the datapath fetch port and the memory controller.

Parameters:
- SETS, 16, number of frames (power of 2); index width IDX_W = log2(SETS).
- TAG_W, 32-2-IDX_W, tag width; address split is tag[31:2+IDX_W], index[1+IDX_W:2], byte offset[1:0] (ignored).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- imemREN  in  1  fetch read request.
- imemaddr  in  32  fetch word address.
- ihit  out  1  request satisfied this cycle.
- imemload  out  32  instruction word; valid when ihit.
- iREN  out  1  memory read request.
- iaddr  out  32  memory read address, word aligned.
- iwait  in  1  memory busy; iload valid when iREN & ~iwait.
- iload  in  32  memory read data.

Behaviour:
- Reset (async, nRST low): all valid bits 0; tags and data 0; state IDLE; ihit 0, imemload 0, iREN 0, iaddr 0; miss_addr reg 0.
- Storage: per frame valid(1), tag(TAG_W), data(32), in flip-flops. Lookup is combinational on imemaddr.
- hit = imemREN & valid[idx] & (tag[idx] == imemaddr tag).
- FSM states are IDLE and FILL.
- IDLE:
  - ihit = hit; imemload = data[idx] when hit, else 0; iREN = 0.
  - On imemREN & ~hit: latch miss_addr = {imemaddr[31:2], 2'b00}, go to FILL.
  - imemREN low: no action, ihit 0.
- FILL:
  - iREN = 1; iaddr = miss_addr; ihit = 0; imemload = 0.
  - iwait high: stay in FILL.
  - iwait low: write frame[miss_addr idx] = {valid 1, miss tag, iload}, go to IDLE.
- Hit latency: 0 cycles (same cycle as request).
- Miss latency: memory wait cycles + 1 fill cycle + 1 cycle. ihit is asserted the cycle after the fill, in IDLE, from the array. It is never asserted directly from iload.
- A fill to a valid frame with a different tag overwrites it (no replacement state).
- Changes to imemREN/imemaddr during FILL (e.g. flush redirect) are ignored. The fill always completes to the latched miss_addr, and the new address is looked up on return to IDLE.
- Simultaneous fill and lookup of the same index cannot happen: no lookup occurs in FILL.
- Reset mid-FILL: return to IDLE, iREN drops immediately, partial data is discarded, all frames are invalid.
- Never writes memory. Read-only; no coherence; self-modifying code is unsupported.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each IDLE cycle with ihit = 1.
  - miss_count increments on each IDLE→FILL transition.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- custom_types_pkg gets:
  - icache_frame_t struct: valid, tag, data.
  - icache_state_t enum: IDLE, FILL.
  - icache_addr_t packed struct: tag, idx, bytoff.
  - Constant ICACHE_SETS = 16.
- Ports are grouped in a new icache_if with modports icache (this block), dp (fetch side), mem (memory controller side).
- Natural sub-module: icache_stats, holding the two saturating counters and instantiated only under ICACHE_STATS_EN.
- FSM and array stay in icache.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x0000_0040, iwait high 3 cycles then low with iload=0x2001_0005.
  - Required: iREN=1 and iaddr=0x40 for 4 cycles, then ihit=1 and imemload=0x2001_0005 one cycle later.
  - Stats: miss_count=1.
- Warm hit: re-request 0x40.
  - Required: ihit=1 in the same cycle, iREN stays 0, imemload=0x2001_0005.
  - Stats: hit_count increments.
- Conflict eviction: fill 0x40, then request 0x0000_0440 (same index 0, different tag) with iload=0xDEAD_BEEF.
  - Required: miss, fill, then hit on 0x440; a following request to 0x40 misses again.
- Redirect mid-fill: enter FILL for 0x80, change imemaddr to 0x100 while iwait high.
  - Required: iaddr stays 0x80 until the fill completes, frame 0 gets 0x80 data, then a new miss to 0x100.
- Reset mid-fill: assert nRST low during FILL.
  - Required: iREN=0 immediately; after release, prior-hit address 0x40 misses (valid bits cleared).
- Idle: imemREN=0 with any address.
  - Required: ihit=0, iREN=0, no state change, counters unchanged.
